// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous RAM between the CPU instruction-fetch
// port (I) and the load/store port (D). The grant is combinational in the
// request cycle. The response is returned one cycle later to whichever port
// owned that access. Priority is either fixed (D over I, with starvation
// relief for I) or round-robin.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RR_MODE    = 0,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_d,
    output logic          m_we,
    input  logic [DW-1:0] m_q,
    output logic          busy
);

    localparam logic       OWN_I      = 1'b0;
    localparam logic       OWN_D      = 1'b1;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic       ready_q,      ready_d;
    logic       rr_last_q,    rr_last_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       resp_vld_q,   resp_vld_d;
    logic       resp_owner_q, resp_owner_d;
    logic       i_win;
    logic       d_win;

    // Pick at most one winner this cycle; nothing is granted until ready
    always_comb begin
        i_win = 1'b0;
        d_win = 1'b0;
        if (ready_q) begin
            if (i_req && d_req) begin
                if (RR_MODE != 0) begin
                    d_win = (rr_last_q == OWN_I);
                end else begin
                    d_win = (starve_cnt_q != STARVE_LIM);
                end
                i_win = !d_win;
            end else begin
                i_win = i_req;
                d_win = d_req;
            end
        end
    end

    assign i_gnt = i_win;
    assign d_gnt = d_win;

    // Steer the winning port onto the RAM; the fetch port never writes
    always_comb begin
        m_addr = '0;
        m_d    = '0;
        m_we   = 1'b0;
        if (d_win) begin
            m_addr = d_addr;
            m_d    = d_wdata;
            m_we   = d_we;
        end else if (i_win) begin
            m_addr = i_addr;
        end
    end

    // Next-state for ready, round-robin pointer, starvation counter and response tag
    always_comb begin
        ready_d      = 1'b1;
        rr_last_d    = rr_last_q;
        resp_owner_d = resp_owner_q;
        resp_vld_d   = i_win || d_win;
        if (i_win) begin
            rr_last_d    = OWN_I;
            resp_owner_d = OWN_I;
        end else if (d_win) begin
            rr_last_d    = OWN_D;
            resp_owner_d = OWN_D;
        end
        if (i_req && !i_win) begin
            starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? STARVE_LIM : starve_cnt_q + 4'd1;
        end else begin
            starve_cnt_d = 4'd0;
        end
    end

    // State registers; reset discards any in-flight response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q      <= 1'b0;
            rr_last_q    <= OWN_I;
            starve_cnt_q <= 4'd0;
            resp_vld_q   <= 1'b0;
            resp_owner_q <= OWN_I;
        end else begin
            ready_q      <= ready_d;
            rr_last_q    <= rr_last_d;
            starve_cnt_q <= starve_cnt_d;
            resp_vld_q   <= resp_vld_d;
            resp_owner_q <= resp_owner_d;
        end
    end

    assign i_rvalid = resp_vld_q && (resp_owner_q == OWN_I);
    assign d_rvalid = resp_vld_q && (resp_owner_q == OWN_D);
    assign i_rdata  = i_rvalid ? m_q : '0;
    assign d_rdata  = d_rvalid ? m_q : '0;
    assign busy     = resp_vld_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. It runs one instance in fixed-priority mode
// and one in round-robin mode. Both share the requester inputs, and each has
// its own read-old-data RAM model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        ram_init;

    logic        i_gnt0, i_rvalid0, d_gnt0, d_rvalid0, m_we0, busy0;
    logic [31:0] i_rdata0, d_rdata0, m_addr0, m_d0, m_q0;
    logic        i_gnt1, i_rvalid1, d_gnt1, d_rvalid1, m_we1, busy1;
    logic [31:0] i_rdata1, d_rdata1, m_addr1, m_d1, m_q1;

    logic [31:0] mem0 [0:63];
    logic [31:0] mem1 [0:63];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .RR_MODE(0), .STARVE_MAX(4)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt0), .i_rvalid(i_rvalid0), .i_rdata(i_rdata0),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt0), .d_rvalid(d_rvalid0), .d_rdata(d_rdata0),
        .m_addr(m_addr0), .m_d(m_d0), .m_we(m_we0), .m_q(m_q0), .busy(busy0)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .RR_MODE(1), .STARVE_MAX(4)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt1), .i_rvalid(i_rvalid1), .i_rdata(i_rdata1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .m_addr(m_addr1), .m_d(m_d1), .m_we(m_we1), .m_q(m_q1), .busy(busy1)
    );

    function automatic logic [31:0] init_val(input int k);
        return (k == 16) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(k);
    endfunction

    // Single-port RAMs, 1-cycle read latency, read returns old data on write
    always @(posedge clk) begin
        if (ram_init) begin
            for (int k = 0; k < 64; k++) mem0[k] <= init_val(k);
        end else begin
            m_q0 <= mem0[m_addr0[5:0]];
            if (m_we0) mem0[m_addr0[5:0]] <= m_d0;
        end
    end

    always @(posedge clk) begin
        if (ram_init) begin
            for (int k = 0; k < 64; k++) mem1[k] <= init_val(k);
        end else begin
            m_q1 <= mem1[m_addr1[5:0]];
            if (m_we1) mem1[m_addr1[5:0]] <= m_d1;
        end
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Request both ports idle, pulse reset, and leave one cycle so ready is set
    task automatic do_reset();
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct packed {
        logic rst_b;
        logic sel;
        logic ir;
        logic dr;
        logic eig;
        logic edg;
        logic eiv;
        logic edv;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    initial begin
        logic [31:0] prev_addr;
        logic [31:0] ia, da;
        logic        ig, dg, iv, dv;
        logic [31:0] ird, drd, ma;

        // fields: rst_b sel | i_req d_req | exp i_gnt d_gnt | exp i_rvalid d_rvalid
        tbl[0]  = 8'b1_0_11_01_00;
        tbl[1]  = 8'b0_0_11_01_01;
        tbl[2]  = 8'b0_0_11_01_01;
        tbl[3]  = 8'b0_0_11_01_01;
        tbl[4]  = 8'b0_0_11_10_01;
        tbl[5]  = 8'b0_0_11_01_10;
        tbl[6]  = 8'b0_0_01_01_01;
        tbl[7]  = 8'b0_0_11_01_01;
        tbl[8]  = 8'b0_0_11_01_01;
        tbl[9]  = 8'b0_0_10_10_01;
        tbl[10] = 8'b0_0_11_01_10;
        tbl[11] = 8'b0_0_11_01_01;
        tbl[12] = 8'b0_0_11_01_01;
        tbl[13] = 8'b0_0_11_01_01;
        tbl[14] = 8'b0_0_11_10_01;
        tbl[15] = 8'b0_0_00_00_10;
        tbl[16] = 8'b1_1_11_01_00;
        tbl[17] = 8'b0_1_11_10_01;
        tbl[18] = 8'b0_1_11_01_10;
        tbl[19] = 8'b0_1_11_10_01;
        tbl[20] = 8'b0_1_10_10_10;
        tbl[21] = 8'b0_1_11_01_10;
        tbl[22] = 8'b0_1_01_01_01;
        tbl[23] = 8'b0_1_11_10_01;
        tbl[24] = 8'b0_1_00_00_10;

        rst_n = 1'b0; ram_init = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        ram_init = 1'b0;

        // T1: reset held with both requests up, then release
        i_req = 1'b1; d_req = 1'b1; d_addr = 32'h11; i_addr = 32'h12;
        #1;
        chk1("rst_i_gnt", i_gnt0, 1'b0);
        chk1("rst_d_gnt", d_gnt0, 1'b0);
        chk1("rst_m_we", m_we0, 1'b0);
        chk32("rst_m_addr", m_addr0, 32'h0);
        chk1("rst_busy", busy0, 1'b0);
        chk1("rst_d_rvalid", d_rvalid0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk1("post_rst_d_gnt", d_gnt0, 1'b0);
        chk1("post_rst_i_gnt", i_gnt0, 1'b0);
        @(negedge clk);
        #1;
        chk1("first_d_gnt", d_gnt0, 1'b1);
        chk32("first_m_addr", m_addr0, 32'h11);
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;
        #1;
        chk1("first_d_rvalid", d_rvalid0, 1'b1);
        chk32("first_d_rdata", d_rdata0, init_val(32'h11));

        // T2: solo fetch
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h10;
        #1;
        chk1("t2_i_gnt", i_gnt0, 1'b1);
        chk1("t2_d_gnt", d_gnt0, 1'b0);
        chk32("t2_m_addr", m_addr0, 32'h10);
        chk1("t2_m_we", m_we0, 1'b0);
        @(negedge clk);
        i_req = 1'b0;
        #1;
        chk1("t2_i_rvalid", i_rvalid0, 1'b1);
        chk32("t2_i_rdata", i_rdata0, 32'hDEADBEEF);
        chk1("t2_d_rvalid", d_rvalid0, 1'b0);
        chk32("t2_d_rdata", d_rdata0, 32'h0);
        chk1("t2_busy", busy0, 1'b1);
        chk32("t2_idle_m_addr", m_addr0, 32'h0);
        @(negedge clk);
        #1;
        chk1("t2_rvalid_once", i_rvalid0, 1'b0);
        chk1("t2_busy_clear", busy0, 1'b0);

        // T3/T4 and extra contention patterns from the vector table
        prev_addr = '0;
        for (int r = 0; r < NV; r++) begin
            if (tbl[r].rst_b) do_reset();
            ia = 32'h30 + 32'(r % 8);
            da = 32'h38 + 32'(r % 8);
            @(negedge clk);
            i_req = tbl[r].ir; d_req = tbl[r].dr; d_we = 1'b0;
            i_addr = ia; d_addr = da;
            #1;
            ig  = tbl[r].sel ? i_gnt1    : i_gnt0;
            dg  = tbl[r].sel ? d_gnt1    : d_gnt0;
            iv  = tbl[r].sel ? i_rvalid1 : i_rvalid0;
            dv  = tbl[r].sel ? d_rvalid1 : d_rvalid0;
            ird = tbl[r].sel ? i_rdata1  : i_rdata0;
            drd = tbl[r].sel ? d_rdata1  : d_rdata0;
            ma  = tbl[r].sel ? m_addr1   : m_addr0;
            chk1($sformatf("vec%0d_i_gnt", r), ig, tbl[r].eig);
            chk1($sformatf("vec%0d_d_gnt", r), dg, tbl[r].edg);
            chk1($sformatf("vec%0d_i_rvalid", r), iv, tbl[r].eiv);
            chk1($sformatf("vec%0d_d_rvalid", r), dv, tbl[r].edv);
            chk32($sformatf("vec%0d_i_rdata", r), ird, tbl[r].eiv ? init_val(int'(prev_addr)) : 32'h0);
            chk32($sformatf("vec%0d_d_rdata", r), drd, tbl[r].edv ? init_val(int'(prev_addr)) : 32'h0);
            chk32($sformatf("vec%0d_m_addr", r), ma, tbl[r].eig ? ia : (tbl[r].edg ? da : 32'h0));
            prev_addr = tbl[r].eig ? ia : da;
        end

        // T5: store then load to the same address
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h5A;
        #1;
        chk1("t5_st_gnt", d_gnt0, 1'b1);
        chk1("t5_st_m_we", m_we0, 1'b1);
        chk32("t5_st_m_d", m_d0, 32'h5A);
        chk32("t5_st_m_addr", m_addr0, 32'h20);
        @(negedge clk);
        d_we = 1'b0;
        #1;
        chk1("t5_st_rvalid", d_rvalid0, 1'b1);
        chk32("t5_st_old_data", d_rdata0, 32'h1000_0020);
        chk1("t5_ld_gnt", d_gnt0, 1'b1);
        chk1("t5_ld_m_we", m_we0, 1'b0);
        @(negedge clk);
        d_req = 1'b0;
        #1;
        chk1("t5_ld_rvalid", d_rvalid0, 1'b1);
        chk32("t5_ld_data", d_rdata0, 32'h5A);

        // T6: reset pulse while a load response is in flight
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h21;
        #1;
        chk1("t6_d_gnt", d_gnt0, 1'b1);
        @(negedge clk);
        d_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk1("t6_d_rvalid_rst", d_rvalid0, 1'b0);
        chk1("t6_busy_rst", busy0, 1'b0);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk1("t6_d_rvalid_after", d_rvalid0, 1'b0);
        chk1("t6_busy_after", busy0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
